jedro_1_lsu: RTL
================

Name: jedro_1_lsu

Overview:
Load-store unit of the jedro_1 core, sitting between decoder/ALU and the data RAM bus (dram_*).
- Accepts one memory op at a time (address, store data, dest reg) and drives the byte-enabled stb/ack/err bus.
- Aligns store data and byte enables, then extracts and sign/zero-extends load data.
- Produces a single-cycle register-file writeback and flags misaligned accesses and bus errors.

Parameters:
DATA_WIDTH, 32, data bus width. Fixed at 32; other values unsupported.
ADDR_WIDTH, 32, address width.
TIMEOUT_CYCLES, 16, ack-wait limit. Used only with the optional feature.

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; synchronous, active-low
ctrl_valid_i  in  1  request valid
ctrl_i  in  4  op, {is_store, funct3}
addr_i  in  ADDR_WIDTH  byte address (rs1+imm)
wdata_i  in  DATA_WIDTH  store data (rs2)
regdest_i  in  5  load destination register
ready_o  out  1  LSU can accept a request this cycle
rdata_o  out  DATA_WIDTH  extended load result
rf_we_o  out  1  writeback strobe, 1 cycle
regdest_o  out  5  writeback register
misaligned_load_o  out  1  exception pulse
misaligned_store_o  out  1  exception pulse
bus_err_o  out  1  bus error / timeout pulse
dram_we  out  4  byte write enables (0000 = read)
dram_stb  out  1  bus request
dram_addr  out  ADDR_WIDTH  word address, low two bits 00
dram_wdata  out  DATA_WIDTH  lane-replicated store data
dram_rdata  in  DATA_WIDTH  read data
dram_ack  in  1  access complete
dram_err  in  1  access failed

Behaviour:
- Reset (rstn_i=0 at a clk_i edge):
  - State goes to IDLE.
  - All outputs 0 except ready_o=1. rdata_o=0, dram_addr=0, dram_wdata=0.
  - Reset during WAIT drops dram_stb at that edge; the pending op is discarded with no writeback.
- States:
  - IDLE: ready_o=1.
  - WAIT: ready_o=0, dram_stb=1, dram_addr/dram_we/dram_wdata held stable.
- Accept: a request is accepted at an edge where ctrl_valid_i && ready_o.
- Op codes: LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1010. Any other code is ignored (no access, no flag).
- Misaligned check:
  - Halfword ops misaligned when addr[0]=1; word ops when addr[1:0]!=00.
  - Result: no bus access, state stays IDLE.
  - misaligned_load_o or misaligned_store_o pulses for exactly the cycle after acceptance.
- Aligned access: enter WAIT at the acceptance edge, so dram_stb is high from the next cycle.
  - dram_addr = {addr[31:2],2'b00}.
  - Loads: dram_we=0000.
  - SB: we = 0001<<off; wdata = {4{wdata_i[7:0]}}.
  - SH: we = 0011<<off; wdata = {2{wdata_i[15:0]}}.
  - SW: we = 1111; wdata = wdata_i.
- Completion: WAIT exits to IDLE at the edge where dram_ack or dram_err is sampled high.
  - If both are high, err wins.
  - Error: bus_err_o pulses 1 cycle; no writeback.
  - Load ack: at that same edge, register the result; rf_we_o pulses high for the following cycle.
    - Byte lane = dram_rdata[8*off +: 8]; halfword lane = dram_rdata[16*off[1] +: 16].
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - Store ack: no writeback.
- Writeback to x0: the access is still performed, but rf_we_o stays 0.
- Latency with a memory that acks in its first stb cycle:
  - Accept at edge E0, stb high in cycle 1, ack sampled at E1, rf_we_o high in cycle 2.
  - ready_o is back to 1 in cycle 2, so back-to-back ops are possible.
- Other rules:
  - Unlimited wait: stb stays asserted until ack/err.
  - Inputs are ignored while in WAIT.

Optional Feature:
JEDRO_1_LSU_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without ack/err:
  - return to IDLE, drop stb;
  - pulse bus_err_o for 1 cycle; no writeback;
  - a late ack is ignored.
- Undefined: no counter; WAIT persists indefinitely.

Decomposition:
- Package jedro_1_defines: lsu_ctrl_e op enum with the encodings above, and LSU_STATE_IDLE/WAIT typedef.
- One sub-module, jedro_1_lsu_load_align: combinational lane extraction and sign/zero-extension from (rdata, offset, op).

Test Plan:
- Word at 0x100 = 0xFFFFFFFF; LW addr 0x100 rd=30 → stb one cycle after accept; rf_we_o the cycle after ack; rdata_o=0xFFFFFFFF; regdest_o=30.
- Word 0x0000_80F0 at 0x104; LB 0x104 → 0xFFFFFFF0; LBU 0x104 → 0x000000F0; LH 0x104 → 0xFFFF80F0; LHU 0x106 → 0x00000000.
- SH addr 0x10A, wdata 0x1234ABCD → dram_we=1100, dram_wdata=0xABCDABCD, dram_addr=0x108; rf_we_o never asserted.
- LW addr 0x102 → misaligned_load_o pulses one cycle; dram_stb stays 0; ready_o stays 1. Same for SW addr 0x101 → misaligned_store_o.
- Memory asserts ack and err together for a load → bus_err_o pulses; no rf_we_o. Reset asserted during a 5-cycle WAIT → stb low the cycle after the reset edge; a subsequent LW completes normally.
- With JEDRO_1_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, memory never acks → bus_err_o after 16 WAIT cycles; an ack arriving at cycle 20 has no effect.

Source files
------------

// File: rtl/jedro_1_defines.sv
// rtl/jedro_1_defines.sv - shared load-store unit types for the jedro_1 core
package jedro_1_defines;

  typedef enum logic [3:0] {
    LSU_LB  = 4'b0000,
    LSU_LH  = 4'b0001,
    LSU_LW  = 4'b0010,
    LSU_LBU = 4'b0100,
    LSU_LHU = 4'b0101,
    LSU_SB  = 4'b1000,
    LSU_SH  = 4'b1001,
    LSU_SW  = 4'b1010
  } lsu_ctrl_e;

  typedef enum logic {
    LSU_STATE_IDLE = 1'b0,
    LSU_STATE_WAIT = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/jedro_1_lsu_load_align.sv
// rtl/jedro_1_lsu_load_align.sv - load lane extraction and sign/zero extension
module jedro_1_lsu_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        fill;

  assign byte_lane = rdata[{offset, 3'b000} +: 8];
  assign half_lane = rdata[{offset[1], 4'b0000} +: 16];

  // funct3[2] marks the unsigned variants
  always_comb begin
    fill   = 1'b0;
    result = rdata;
    case (funct3[1:0])
      2'b00: begin
        fill   = ~funct3[2] & byte_lane[7];
        result = {{24{fill}}, byte_lane};
      end
      2'b01: begin
        fill   = ~funct3[2] & half_lane[15];
        result = {{16{fill}}, half_lane};
      end
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// rtl/jedro_1_lsu.sv - jedro_1 load-store unit; optional ack timeout via JEDRO_1_LSU_TIMEOUT_EN
module jedro_1_lsu
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ctrl_valid_i,
  input  logic [3:0]            ctrl_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [4:0]            regdest_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rf_we_o,
  output logic [4:0]            regdest_o,
  output logic                  misaligned_load_o,
  output logic                  misaligned_store_o,
  output logic                  bus_err_o,
  output logic [3:0]            dram_we,
  output logic                  dram_stb,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  input  logic                  dram_ack,
  input  logic                  dram_err
);

  lsu_state_e            state_q, state_d;
  logic [3:0]            op_q;
  logic [1:0]            off_q;
  logic [4:0]            regdest_q;
  logic                  accept, known, misaligned, go, in_wait, timeout;
  logic [3:0]            we_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] load_result;

  assign in_wait  = (state_q == LSU_STATE_WAIT);
  assign ready_o  = (state_q == LSU_STATE_IDLE);
  assign dram_stb = in_wait;
  assign accept   = ctrl_valid_i && ready_o;
  assign misaligned = ((ctrl_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((ctrl_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  assign go = accept && known && !misaligned;

  always_comb begin
    known   = 1'b0;
    we_d    = 4'b0000;
    wdata_d = wdata_i;
    case (ctrl_i)
      LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU: known = 1'b1;
      LSU_SB: begin
        known   = 1'b1;
        we_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      LSU_SH: begin
        known   = 1'b1;
        we_d    = 4'b0011 << addr_i[1:0];
        wdata_d = {2{wdata_i[15:0]}};
      end
      LSU_SW: begin
        known = 1'b1;
        we_d  = 4'b1111;
      end
      default: known = 1'b0;
    endcase
  end

`ifdef JEDRO_1_LSU_TIMEOUT_EN
  logic [31:0] wait_cnt_q;

  // counts completed WAIT cycles; timeout fires on the last allowed one
  assign timeout = in_wait && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i || go) wait_cnt_q <= '0;
    else if (in_wait)  wait_cnt_q <= wait_cnt_q + 32'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_STATE_IDLE: if (go) state_d = LSU_STATE_WAIT;
      LSU_STATE_WAIT: if (dram_ack || dram_err || timeout) state_d = LSU_STATE_IDLE;
      default:        state_d = LSU_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= LSU_STATE_IDLE;
    else         state_q <= state_d;
  end

  jedro_1_lsu_load_align u_load_align (
    .rdata  (dram_rdata),
    .offset (off_q),
    .funct3 (op_q[2:0]),
    .result (load_result)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      op_q               <= '0;
      off_q              <= '0;
      regdest_q          <= '0;
      dram_we            <= '0;
      dram_addr          <= '0;
      dram_wdata         <= '0;
      rdata_o            <= '0;
      rf_we_o            <= 1'b0;
      regdest_o          <= '0;
      misaligned_load_o  <= 1'b0;
      misaligned_store_o <= 1'b0;
      bus_err_o          <= 1'b0;
    end else begin
      misaligned_load_o  <= accept && known && misaligned && !ctrl_i[3];
      misaligned_store_o <= accept && known && misaligned && ctrl_i[3];
      bus_err_o          <= in_wait && (dram_err || (timeout && !dram_ack));
      rf_we_o            <= 1'b0;
      if (go) begin
        op_q       <= ctrl_i;
        off_q      <= addr_i[1:0];
        regdest_q  <= regdest_i;
        dram_we    <= we_d;
        dram_addr  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        dram_wdata <= wdata_d;
      end
      // error outranks ack; x0 loads still run on the bus but never write back
      if (in_wait && dram_ack && !dram_err && !op_q[3]) begin
        rdata_o   <= load_result;
        regdest_o <= regdest_q;
        rf_we_o   <= (regdest_q != 5'd0);
      end
    end
  end

endmodule
